// File: rtl/vga_pkg.sv
// Shared VGA overlay types and constants: coordinate/colour widths,
// rectangle configuration record, and named colours.
package vga_pkg;

   localparam int COORD_W = 10;
   localparam int COLOR_W = 12;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] w;
      logic [COORD_W-1:0] h;
      logic [COLOR_W-1:0] color;
      logic               vis;
   } rect_cfg_t;

   localparam logic [COLOR_W-1:0] BG_COLOR    = 12'h000;
   localparam logic [COLOR_W-1:0] COLOR_RED   = 12'hF00;
   localparam logic [COLOR_W-1:0] COLOR_GREEN = 12'h0F0;
   localparam logic [COLOR_W-1:0] COLOR_BLUE  = 12'h00F;
   localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;

   // Exclusive end coordinate, one bit wider so an edge past the screen clips instead of wrapping.
   function automatic logic [COORD_W:0] coord_end(input logic [COORD_W-1:0] org,
                                                  input logic [COORD_W-1:0] len);
      return {1'b0, org} + {1'b0, len};
   endfunction

endpackage

// File: rtl/rect_hit.sv
// Single-rectangle coverage test: is pixel (x, y) inside an enabled rectangle?
// Purely combinational; one instance per rectangle.
module rect_hit
   import vga_pkg::*;
(
   input  rect_cfg_t          cfg_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic               hit_o
);

   logic [COORD_W:0] x_end;
   logic [COORD_W:0] y_end;
   logic             in_x;
   logic             in_y;
   logic             unused_color;

   assign unused_color = ^cfg_i.color;

   // Half-open range test on both axes; a zero width or height gives an empty range.
   always_comb begin
      x_end = coord_end(cfg_i.x0, cfg_i.w);
      y_end = coord_end(cfg_i.y0, cfg_i.h);
      in_x  = (x_i >= cfg_i.x0) && ({1'b0, x_i} < x_end);
      in_y  = (y_i >= cfg_i.y0) && ({1'b0, y_i} < y_end);
      hit_o = cfg_i.vis && in_x && in_y;
   end

endmodule

// File: rtl/rect_layer.sv
// Multi-rectangle overlay renderer. Double-buffered rectangle configuration
// (shadow written any time, active loaded at frame start), parallel hit test,
// and a 2-stage pipeline ending in a priority-encoded colour.
module rect_layer #(
   parameter int                       N_RECT   = 4,
   parameter int                       COORD_W  = vga_pkg::COORD_W,
   parameter int                       COLOR_W  = vga_pkg::COLOR_W,
   parameter logic [COLOR_W-1:0]       BG_COLOR = vga_pkg::BG_COLOR,
   localparam int                      IDX_W    = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               display,
   input  logic               frame_start,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [COORD_W-1:0] wr_x0,
   input  logic [COORD_W-1:0] wr_y0,
   input  logic [COORD_W-1:0] wr_w,
   input  logic [COORD_W-1:0] wr_h,
   input  logic [COLOR_W-1:0] wr_color,
   input  logic               wr_vis,
   output logic               pending,
   output logic [COLOR_W-1:0] rgb,
   output logic               hit,
   output logic [IDX_W-1:0]   hit_idx,
   output logic               display_q
);

   import vga_pkg::*;

   // Configuration banks
   rect_cfg_t          shadow_q [N_RECT];
   rect_cfg_t          shadow_d [N_RECT];
   rect_cfg_t          active_q [N_RECT];
   rect_cfg_t          active_d [N_RECT];
   logic [N_RECT-1:0]  dirty_q;
   logic [N_RECT-1:0]  dirty_d;
   rect_cfg_t          wr_cfg;
   logic               wr_ok;

   // Stage 1
   logic [N_RECT-1:0]  hit_vec;
   logic [N_RECT-1:0]  hit_vec_q;
   logic               disp1_q;
   logic [COLOR_W-1:0] color1_q [N_RECT];

   // Stage 2
   logic [COLOR_W-1:0] rgb_q;
   logic [COLOR_W-1:0] rgb_d;
   logic               hit_q;
   logic               hit_d;
   logic [IDX_W-1:0]   hit_idx_q;
   logic [IDX_W-1:0]   hit_idx_d;
   logic               disp2_q;

   // Commit reads the pre-write shadow, so a write landing on the frame_start
   // edge stays dirty and waits for the following frame.
   always_comb begin
      wr_cfg   = '{x0: wr_x0, y0: wr_y0, w: wr_w, h: wr_h, color: wr_color, vis: wr_vis};
      wr_ok    = wr_en && (int'(wr_idx) < N_RECT);
      shadow_d = shadow_q;
      active_d = active_q;
      dirty_d  = dirty_q;
      if (frame_start) begin
         for (int unsigned i = 0; i < N_RECT; i++) begin
            if (dirty_q[i]) begin
               active_d[i] = shadow_q[i];
            end
         end
         dirty_d = '0;
      end
      if (wr_ok) begin
         shadow_d[wr_idx] = wr_cfg;
         dirty_d[wr_idx]  = 1'b1;
      end
   end

   // Shadow/active banks and dirty flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_RECT; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         dirty_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         dirty_q  <= dirty_d;
      end
   end

   assign pending = |dirty_q;

   for (genvar g = 0; g < N_RECT; g++) begin : g_hit
      rect_hit u_rect_hit (
         .cfg_i (active_q[g]),
         .x_i   (x),
         .y_i   (y),
         .hit_o (hit_vec[g])
      );
   end

   // Stage 1: capture hit vector, display flag and a colour snapshot so a
   // commit on this edge cannot recolour a pixel already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_vec_q <= '0;
         disp1_q   <= 1'b0;
         for (int unsigned i = 0; i < N_RECT; i++) begin
            color1_q[i] <= '0;
         end
      end else begin
         hit_vec_q <= hit_vec;
         disp1_q   <= display;
         for (int unsigned i = 0; i < N_RECT; i++) begin
            color1_q[i] <= active_q[i].color;
         end
      end
   end

   // Priority encode: lowest hitting index wins; blanking forces background.
   always_comb begin
      rgb_d     = BG_COLOR;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      if (disp1_q) begin
         for (int unsigned i = 0; i < N_RECT; i++) begin
            if (hit_vec_q[i] && !hit_d) begin
               rgb_d     = color1_q[i];
               hit_d     = 1'b1;
               hit_idx_d = IDX_W'(i);
            end
         end
      end
   end

   // Stage 2: registered pixel outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q     <= BG_COLOR;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
         disp2_q   <= 1'b0;
      end else begin
         rgb_q     <= rgb_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
         disp2_q   <= disp1_q;
      end
   end

   assign rgb       = rgb_q;
   assign hit       = hit_q;
   assign hit_idx   = hit_idx_q;
   assign display_q = disp2_q;

endmodule

// File: tb/tb_rect_layer.sv
// Self-checking bench for rect_layer: directed scenarios with fixed expected
// values plus a randomized run against a behavioural frame/overlay model.
module tb_rect_layer;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        display = 1'b0;
   logic        frame_start = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_idx = '0;
   logic [9:0]  wr_x0 = '0;
   logic [9:0]  wr_y0 = '0;
   logic [9:0]  wr_w = '0;
   logic [9:0]  wr_h = '0;
   logic [11:0] wr_color = '0;
   logic        wr_vis = 1'b0;
   logic        pending;
   logic [11:0] rgb;
   logic        hit;
   logic [1:0]  hit_idx;
   logic        display_q;

   always #5 clk = ~clk;

   rect_layer #(
      .N_RECT   (4),
      .COORD_W  (10),
      .COLOR_W  (12),
      .BG_COLOR (12'h000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .display     (display),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_x0       (wr_x0),
      .wr_y0       (wr_y0),
      .wr_w        (wr_w),
      .wr_h        (wr_h),
      .wr_color    (wr_color),
      .wr_vis      (wr_vis),
      .pending     (pending),
      .rgb         (rgb),
      .hit         (hit),
      .hit_idx     (hit_idx),
      .display_q   (display_q)
   );

   typedef struct {int x0; int y0; int w; int h; int col; bit vis;} mrect_t;
   typedef struct {int rgb; bit hit; int idx; bit disp;} mexp_t;

   mrect_t m_sh  [N];
   mrect_t m_act [N];
   bit     m_dirty [N];
   mexp_t  exp_q [$];
   mexp_t  cur;
   bit     cur_valid;
   int     tests_run = 0;
   int     tests_failed = 0;

   // What the screen should show for one pixel given the committed rectangles.
   function automatic mexp_t model_pixel(input int px, input int py, input bit disp);
      mexp_t e;
      e.rgb = 0; e.hit = 1'b0; e.idx = 0; e.disp = disp;
      if (disp) begin
         for (int i = 0; i < N; i++) begin
            if (!e.hit && m_act[i].vis &&
                px >= m_act[i].x0 && px < m_act[i].x0 + m_act[i].w &&
                py >= m_act[i].y0 && py < m_act[i].y0 + m_act[i].h) begin
               e.rgb = m_act[i].col; e.hit = 1'b1; e.idx = i;
            end
         end
      end
      return e;
   endfunction

   function automatic bit model_pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) p |= m_dirty[i];
      return p;
   endfunction

   task automatic model_reset();
      mexp_t r;
      for (int i = 0; i < N; i++) begin
         m_sh[i]  = '{0, 0, 0, 0, 0, 1'b0};
         m_act[i] = '{0, 0, 0, 0, 0, 1'b0};
         m_dirty[i] = 1'b0;
      end
      exp_q = {};
      r.rgb = 0; r.hit = 1'b0; r.idx = 0; r.disp = 1'b0;
      exp_q.push_back(r);
   endtask

   // Advance one clock with the current inputs; the model follows the frame rules.
   task automatic tick();
      exp_q.push_back(model_pixel(int'(x), int'(y), display));
      if (frame_start) begin
         for (int i = 0; i < N; i++) begin
            if (m_dirty[i]) m_act[i] = m_sh[i];
            m_dirty[i] = 1'b0;
         end
      end
      if (wr_en) begin
         m_sh[wr_idx] = '{int'(wr_x0), int'(wr_y0), int'(wr_w), int'(wr_h), int'(wr_color), wr_vis};
         m_dirty[wr_idx] = 1'b1;
      end
      @(posedge clk); #1;
      cur_valid = 1'b0;
      if (exp_q.size() > 1) begin
         cur = exp_q.pop_front();
         cur_valid = 1'b1;
      end
   endtask

   task automatic do_write(input int idx, input int x0, input int y0, input int w, input int h,
                           input int col, input bit vis);
      wr_en = 1'b1; wr_idx = 2'(idx); wr_x0 = 10'(x0); wr_y0 = 10'(y0);
      wr_w = 10'(w); wr_h = 10'(h); wr_color = 12'(col); wr_vis = vis;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_commit();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Hold a pixel for two clocks so the outputs show it.
   task automatic probe(input int px, input int py, input bit disp);
      x = 10'(px); y = 10'(py); display = disp;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         frame_start = (i % 2 == 0);
         x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023)); display = 1'b1;
         @(posedge clk); #1;
         tests_run++;
         if (rgb !== 12'h000 || hit !== 1'b0 || hit_idx !== 2'd0 || display_q !== 1'b0 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold got rgb=%h hit=%b idx=%0d dq=%b pend=%b want 000 0 0 0 0",
                     rgb, hit, hit_idx, display_q, pending);
         end
      end
      frame_start = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023)); display = 1'b1;
         frame_start = (i == 3);
         tick();
         tests_run++;
         if (rgb !== 12'h000 || hit !== 1'b0 || pending !== 1'b0 || display_q !== (i > 0)) begin
            tests_failed++;
            $display("FAIL reset_defaults cyc=%0d got rgb=%h hit=%b pend=%b dq=%b want 000 0 0 %b",
                     i, rgb, hit, pending, display_q, (i > 0));
         end
      end
      frame_start = 1'b0;
   endtask

   task automatic test_basic_hit();
      do_write(0, 100, 50, 20, 10, 12'hF00, 1'b1);
      tests_run++;
      if (pending !== 1'b1) begin
         tests_failed++; $display("FAIL basic_pending_set got %b want 1", pending);
      end
      do_commit();
      tests_run++;
      if (pending !== 1'b0) begin
         tests_failed++; $display("FAIL basic_pending_clr got %b want 0", pending);
      end
      x = 10'd0; y = 10'd0; display = 1'b1;
      tick(); tick();
      x = 10'd100; y = 10'd50;
      tick();
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL basic_latency_early got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      x = 10'd0; y = 10'd0;
      tick();
      tests_run++;
      if (rgb !== 12'hF00 || hit !== 1'b1 || hit_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL basic_corner got rgb=%h hit=%b idx=%0d want F00 1 0", rgb, hit, hit_idx);
      end
      tick();
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL basic_latency_late got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      probe(119, 59, 1'b1);
      tests_run++;
      if (rgb !== 12'hF00 || hit !== 1'b1) begin
         tests_failed++; $display("FAIL basic_far_corner got rgb=%h hit=%b want F00 1", rgb, hit);
      end
      probe(120, 59, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL basic_right_edge got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      probe(100, 60, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL basic_bottom_edge got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      probe(99, 50, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL basic_left_edge got rgb=%h hit=%b want 000 0", rgb, hit);
      end
   endtask

   task automatic test_priority();
      do_write(0, 0, 0, 50, 50, 12'h0F0, 1'b1);
      do_write(2, 10, 10, 50, 50, 12'h00F, 1'b1);
      do_commit();
      probe(20, 20, 1'b1);
      tests_run++;
      if (rgb !== 12'h0F0 || hit !== 1'b1 || hit_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL prio_overlap got rgb=%h hit=%b idx=%0d want 0F0 1 0", rgb, hit, hit_idx);
      end
      probe(55, 55, 1'b1);
      tests_run++;
      if (rgb !== 12'h00F || hit !== 1'b1 || hit_idx !== 2'd2) begin
         tests_failed++;
         $display("FAIL prio_low got rgb=%h hit=%b idx=%0d want 00F 1 2", rgb, hit, hit_idx);
      end
      probe(105, 55, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0 || hit_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL prio_replaced got rgb=%h hit=%b idx=%0d want 000 0 0", rgb, hit, hit_idx);
      end
   endtask

   task automatic test_double_buffer();
      do_write(1, 200, 100, 30, 30, 12'h0FF, 1'b1);
      probe(210, 110, 1'b1);
      tests_run++;
      if (pending !== 1'b1 || rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL dbuf_before got pend=%b rgb=%h hit=%b want 1 000 0", pending, rgb, hit);
      end
      do_commit();
      tests_run++;
      if (pending !== 1'b0) begin
         tests_failed++; $display("FAIL dbuf_commit_pend got %b want 0", pending);
      end
      probe(210, 110, 1'b1);
      tests_run++;
      if (rgb !== 12'h0FF || hit !== 1'b1 || hit_idx !== 2'd1) begin
         tests_failed++;
         $display("FAIL dbuf_after got rgb=%h hit=%b idx=%0d want 0FF 1 1", rgb, hit, hit_idx);
      end
      frame_start = 1'b1;
      do_write(1, 200, 100, 30, 30, 12'hAAA, 1'b1);
      frame_start = 1'b0;
      tests_run++;
      if (pending !== 1'b1) begin
         tests_failed++; $display("FAIL dbuf_coincide_pend got %b want 1", pending);
      end
      probe(210, 110, 1'b1);
      tests_run++;
      if (rgb !== 12'h0FF || hit_idx !== 2'd1) begin
         tests_failed++;
         $display("FAIL dbuf_coincide_hold got rgb=%h idx=%0d want 0FF 1", rgb, hit_idx);
      end
      do_commit();
      probe(210, 110, 1'b1);
      tests_run++;
      if (rgb !== 12'hAAA || hit !== 1'b1 || pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL dbuf_coincide_next got rgb=%h hit=%b pend=%b want AAA 1 0", rgb, hit, pending);
      end
   endtask

   task automatic test_clip_blank();
      do_write(3, 1000, 400, 100, 10, 12'h5A5, 1'b1);
      do_write(1, 300, 300, 0, 10, 12'hFFF, 1'b1);
      do_commit();
      probe(5, 405, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL clip_nowrap got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      probe(1023, 405, 1'b1);
      tests_run++;
      if (rgb !== 12'h5A5 || hit !== 1'b1 || hit_idx !== 2'd3) begin
         tests_failed++;
         $display("FAIL clip_edge got rgb=%h hit=%b idx=%0d want 5A5 1 3", rgb, hit, hit_idx);
      end
      probe(300, 305, 1'b1);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0) begin
         tests_failed++; $display("FAIL zero_width got rgb=%h hit=%b want 000 0", rgb, hit);
      end
      probe(20, 20, 1'b0);
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0 || hit_idx !== 2'd0 || display_q !== 1'b0) begin
         tests_failed++;
         $display("FAIL blanking got rgb=%h hit=%b idx=%0d dq=%b want 000 0 0 0", rgb, hit, hit_idx, display_q);
      end
      probe(20, 20, 1'b1);
      tests_run++;
      if (rgb !== 12'h0F0 || hit !== 1'b1 || display_q !== 1'b1) begin
         tests_failed++;
         $display("FAIL unblank got rgb=%h hit=%b dq=%b want 0F0 1 1", rgb, hit, display_q);
      end
   endtask

   task automatic test_random();
      int r, px, py;
      for (int c = 0; c < 1500; c++) begin
         wr_en = ($urandom_range(0, 7) == 0);
         if (wr_en) begin
            wr_idx   = 2'($urandom_range(0, 3));
            wr_x0    = 10'($urandom_range(0, 1023));
            wr_y0    = 10'($urandom_range(0, 1023));
            wr_w     = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 300));
            wr_h     = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 300));
            wr_color = 12'($urandom);
            wr_vis   = ($urandom_range(0, 7) != 0);
         end
         frame_start = ($urandom_range(0, 19) == 0);
         display = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 1) == 0) begin
            r  = int'($urandom_range(0, 3));
            px = (($urandom_range(0, 1) != 0) ? m_act[r].x0 : m_act[r].x0 + m_act[r].w)
                 + int'($urandom_range(0, 2)) - 1;
            py = (($urandom_range(0, 1) != 0) ? m_act[r].y0 : m_act[r].y0 + m_act[r].h)
                 + int'($urandom_range(0, 2)) - 1;
            x = 10'(px & 1023);
            y = 10'(py & 1023);
         end else begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
         end
         tick();
         if (cur_valid) begin
            tests_run++;
            if ({rgb, hit, hit_idx, display_q} !== {12'(cur.rgb), cur.hit, 2'(cur.idx), cur.disp}) begin
               tests_failed++;
               $display("FAIL random_pixel cyc=%0d got rgb=%h hit=%b idx=%0d dq=%b want rgb=%h hit=%b idx=%0d dq=%b",
                        c, rgb, hit, hit_idx, display_q, 12'(cur.rgb), cur.hit, cur.idx, cur.disp);
            end
         end
         tests_run++;
         if (pending !== model_pending()) begin
            tests_failed++;
            $display("FAIL random_pending cyc=%0d got %b want %b", c, pending, model_pending());
         end
      end
      wr_en = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic test_reset_midframe();
      do_write(0, 0, 0, 50, 50, 12'hF0F, 1'b1);
      do_commit();
      do_write(2, 0, 0, 10, 10, 12'h123, 1'b1);
      probe(10, 10, 1'b1);
      tests_run++;
      if (rgb !== 12'hF0F || hit !== 1'b1 || pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_pre got rgb=%h hit=%b pend=%b want F0F 1 1", rgb, hit, pending);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0 || hit_idx !== 2'd0 || display_q !== 1'b0 || pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_immediate got rgb=%h hit=%b idx=%0d dq=%b pend=%b want 000 0 0 0 0",
                  rgb, hit, hit_idx, display_q, pending);
      end
      @(posedge clk); #3;
      model_reset();
      rst_n = 1'b1;
      tick();
      tick();
      tests_run++;
      if (rgb !== 12'h000 || hit !== 1'b0 || display_q !== 1'b1 || pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_cleared got rgb=%h hit=%b dq=%b pend=%b want 000 0 1 0",
                  rgb, hit, display_q, pending);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_basic_hit();
      test_priority();
      test_double_buffer();
      test_clip_blank();
      test_random();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rect_layer.md
# rect_layer

Multi-rectangle overlay renderer for the VGA pixel path. It holds `N_RECT` programmable rectangles. Each rectangle has its own position, size, colour and enable bit. Every pixel coordinate from the VGA timing generator is tested against all rectangles, and the block outputs the colour of the highest-priority hit through a 2-stage registered pipeline. Rectangle updates are double-buffered and take effect only at frame start, so no tearing occurs mid-frame. The block sits between the VGA sync/counter block and the final RGB output mux.

## Interface
Parameters:
- `N_RECT`, 4: number of rectangles; index 0 has the highest priority.
- `COORD_W`, 10: width of the pixel coordinate and size fields.
- `COLOR_W`, 12: RGB width (4:4:4).
- `BG_COLOR`, 12'h000: colour driven on a miss or during blanking.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `x`, `y` in `COORD_W`: current pixel coordinate.
- `display` in 1: visible-area flag, aligned with `x`/`y`.
- `frame_start` in 1: single-cycle pulse at the start of vertical blanking.
- `wr_en` in 1: write strobe for the shadow configuration.
- `wr_idx` in `$clog2(N_RECT)`: rectangle being written.
- `wr_x0`, `wr_y0`, `wr_w`, `wr_h` in `COORD_W`: rectangle geometry.
- `wr_color` in `COLOR_W`: fill colour.
- `wr_vis` in 1: rectangle enable.
- `pending` out 1: at least one shadow entry is not yet committed.
- `rgb` out `COLOR_W`: pixel colour, 2 cycles after `x`/`y`.
- `hit` out 1: some enabled rectangle covers the pixel (pipelined with `rgb`).
- `hit_idx` out `$clog2(N_RECT)`: winning rectangle index; 0 when `hit`=0.
- `display_q` out 1: `display` delayed by 2 cycles.

## Operation
- There are two register banks per rectangle, shadow and active. Each entry holds {x0, y0, w, h, color, vis} plus a per-entry `dirty` bit.
- **Write:** when `wr_en`=1 at a clock edge, the shadow entry `wr_idx` is overwritten and its `dirty` bit is set. Writes are accepted every cycle. If `wr_idx` >= `N_RECT`, the write is ignored.
- **Commit:** when `frame_start`=1, every shadow entry whose `dirty`=1 is copied to active, and all `dirty` bits are cleared.
  - If a write coincides with `frame_start`, the write lands in shadow with `dirty`=1 and is not included in this commit. It waits for the next `frame_start`.
  - `pending` is the OR of all `dirty` bits.
- **Hit test:** for each active entry, `vis && x >= x0 && x < x0+w && y >= y0 && y < y0+h`.
  - The sums `x0+w` and `y0+h` are computed at `COORD_W+1` bits, with no wrap. A rectangle running past coordinate 1023 is therefore clipped, not wrapped to 0.
  - `w`=0 or `h`=0 never hits.
- **Priority:** the lowest hitting index wins and supplies `color`.
- **Blanking:** when the delayed `display`=0, the output is `rgb`=`BG_COLOR`, `hit`=0, `hit_idx`=0. The rectangle compare results are ignored.
- **Miss:** with `display`=1 and no rectangle hit, the output is `rgb`=`BG_COLOR`, `hit`=0.

## Timing
- **Stage 1 (edge N+1):** registers the per-rectangle hit vector, the `display` flag, and a copy of each active colour.
- **Stage 2 (edge N+2):** registers the priority-encoded `rgb`, `hit`, `hit_idx` and `display_q`.
- **Latency:** the pixel presented at edge N appears at the outputs after edge N+2. Throughput is one pixel per clock.
- **Reset:**
  - All shadow and active entries are cleared (vis=0, all fields 0), and all `dirty` bits are 0.
  - Outputs reset to `rgb`=`BG_COLOR`, `hit`=0, `hit_idx`=0, `display_q`=0, `pending`=0.
  - Reset asserted mid-frame clears the pipeline immediately. The first valid output appears 2 edges after `rst_n` rises.
- **Commit vs. pipeline:** active registers change at the `frame_start` edge. Pixels already in stage 1 keep the colour they captured.

## Structure
- **Shared package `vga_pkg`:**
  - Constants `COORD_W` and `COLOR_W`.
  - Struct `rect_cfg_t` {x0, y0, w, h, color, vis}.
  - Colour constants, including the `BG_COLOR` default.
- **Sub-module `rect_hit`:** the single-rectangle compare (`rect_cfg_t`, x, y → hit), with the widened sums. It is combinational and instantiated `N_RECT` times in a generate loop.
- **Top `rect_layer`:** holds the register banks, the commit logic, the priority encoder and the pipeline registers.

## Test plan
- **Reset defaults:** assert reset with `frame_start` pulses and no writes → `rgb`=000, `hit`=0 on every pixel, `pending`=0.
- **Basic hit:** write idx0 {x0=100, y0=50, w=20, h=10, color=F00, vis=1}, then pulse `frame_start`.
  - Pixel (100,50) → `rgb`=F00, `hit_idx`=0 exactly 2 cycles later.
  - Pixels (119,59) → F00; (120,59) → miss; (100,60) → miss.
- **Priority:** idx0 {0,0,50,50,0F0} overlapping idx2 {10,10,50,50,00F}.
  - Pixel (20,20) → 0F0, `hit_idx`=0.
  - Pixel (55,55) → 00F, `hit_idx`=2.
- **Double buffering:** write idx1 mid-frame → `pending`=1 and the output is unchanged until `frame_start`; it changes after commit, then `pending`=0.
  - A write on the same cycle as `frame_start` → `pending` stays 1 and the change becomes visible only after the next `frame_start`.
- **Clipping and blanking:** {x0=1000, w=100} with x=5 → miss, no wrap. `w`=0 → never hits. `display`=0 over a hit region → `rgb`=`BG_COLOR`, `hit`=0.
- **Reset mid-frame:** reset while `hit`=1 → outputs go to their reset values immediately, and the active entries are cleared.
